cbus_arbiter: RTL
=================

# cbus_arbiter

Two-requester memory-port arbiter for the pipelined core: multiplexes the instruction-fetch port (ibus) and the data port (dbus) onto the single core bus (cbus) to memory/cache. It latches the winning request, holds it stable on cbus until the last response beat, returns the data to the owner, and produces the `i_wait`/`d_wait` stall inputs consumed by the hazard unit.

## Interface
Parameters:
- `ADDR_W`, 64, address width on all ports
- `DATA_W`, 64, cbus/dbus data width; ibus data is the low 32 bits

Ports:
- `clk`  in  1  clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `i_req_valid`  in  1  fetch request pending
- `i_req_addr`  in  ADDR_W  fetch address
- `i_data_ok`  out  1  fetch response valid (one-cycle pulse)
- `i_data`  out  32  fetch data, valid with `i_data_ok`
- `d_req_valid`  in  1  load/store request pending
- `d_req_write`  in  1  1 = store
- `d_req_size`  in  3  access size code (0=1B,1=2B,2=4B,3=8B)
- `d_req_addr`  in  ADDR_W  data address
- `d_req_strobe`  in  DATA_W/8  store byte enables
- `d_req_wdata`  in  DATA_W  store data
- `d_data_ok`  out  1  data response valid (one-cycle pulse)
- `d_data`  out  DATA_W  load data, valid with `d_data_ok`
- `creq_valid`  out  1  cbus request valid
- `creq_write`  out  1  cbus store
- `creq_size`  out  3  cbus size
- `creq_addr`  out  ADDR_W  cbus address
- `creq_strobe`  out  DATA_W/8  cbus byte enables
- `creq_wdata`  out  DATA_W  cbus store data
- `cresp_ready`  in  1  cbus response beat valid
- `cresp_last`  in  1  final beat of transaction
- `cresp_data`  in  DATA_W  cbus read data
- `i_wait`  out  1  fetch stalled (to hazard unit)
- `d_wait`  out  1  data access stalled (to hazard unit)

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D. Reset: IDLE, priority pointer = data-first.
- IDLE: if any request valid, select winner, latch its fields into the request register, move to GRANT_I/GRANT_D. Fetch latched as read, size 2, strobe 0, wdata 0.
- GRANT_x: `creq_*` driven from the latched register only; requester input changes ignored. Stay until `cresp_ready && cresp_last`, then return to IDLE.
- `cresp_ready` without `cresp_last`: beat ignored, remain in grant. `cresp_ready` in IDLE: ignored.
- Response: in GRANT_x on the last beat, `x_data_ok`=1 same cycle; `i_data`=`cresp_data[31:0]`, `d_data`=`cresp_data`; both data outputs 0 otherwise.
- `i_wait = i_req_valid && !i_data_ok`; `d_wait = d_req_valid && !d_data_ok`.
- Requesters hold valid until their `data_ok`; if valid drops mid-grant the transaction still completes and `data_ok` still pulses.
- Priority pointer updates on grant to the loser-first value when round-robin is enabled (see Configuration).

## Timing
- All `creq_*`, state, pointer registered; `creq_valid`=1 exactly in GRANT states. Reset values: every output 0.
- Request seen in IDLE at cycle n → `creq_valid` from cycle n+1.
- Last beat at cycle m → `data_ok` at m (combinational), state IDLE at m+1, next grant at m+2 earliest (one-cycle bubble).
- Minimum fetch latency with zero-wait memory: request n, `data_ok` n+1.
- `resetn` low mid-grant: immediate return to IDLE, `creq_valid`=0, no `data_ok`; later responses ignored until a new grant.

## Configuration
- `CBUS_ARB_RR_EN` defined: when both requests valid in IDLE, grant alternates; pointer after a D grant favours I, after an I grant favours D. Single requests always granted.
- Not defined: fixed priority, dbus always wins on simultaneous requests; pointer logic absent.

## Test plan
- Reset: `resetn`=0 with both requests valid → all outputs 0, IDLE; release → `creq_valid`=1 next cycle for dbus.
- Single fetch, addr 0x8000_0000, memory replies next cycle data 0x00000013 last=1 → `i_data_ok`=1, `i_data`=0x13, `i_wait` 1→0.
- Store size 3, strobe 0xFF, wdata 0xDEAD_BEEF, 3-cycle response with 2 non-last beats → `creq_*` stable all cycles, `d_data_ok` only on last beat.
- Both valid continuously, 4 transactions: with `CBUS_ARB_RR_EN` grant order D,I,D,I; without, D,D,D,D while `i_wait` stays 1.
- Change `d_req_addr` mid-grant 0x100→0x200 → `creq_addr` stays 0x100 until done.
- Assert `resetn`=0 mid-grant, then deliver stale `cresp_last` in IDLE → no `data_ok` pulse, state IDLE.

Source files
------------

// File: rtl/cbus_arbiter.sv
// Two-requester (ibus/dbus) arbiter onto the single core bus, with stall outputs for the hazard unit.
// Optional macro CBUS_ARB_RR_EN: round-robin between simultaneous requests (default: dbus always wins).
module cbus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                resetn,
    // instruction-fetch port
    input  logic                i_req_valid,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic                i_data_ok,
    output logic [31:0]         i_data,
    // data port
    input  logic                d_req_valid,
    input  logic                d_req_write,
    input  logic [2:0]          d_req_size,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W/8-1:0] d_req_strobe,
    input  logic [DATA_W-1:0]   d_req_wdata,
    output logic                d_data_ok,
    output logic [DATA_W-1:0]   d_data,
    // core bus
    output logic                creq_valid,
    output logic                creq_write,
    output logic [2:0]          creq_size,
    output logic [ADDR_W-1:0]   creq_addr,
    output logic [DATA_W/8-1:0] creq_strobe,
    output logic [DATA_W-1:0]   creq_wdata,
    input  logic                cresp_ready,
    input  logic                cresp_last,
    input  logic [DATA_W-1:0]   cresp_data,
    // stalls to hazard unit
    output logic                i_wait,
    output logic                d_wait
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_creq_valid;
    logic                r_creq_write;
    logic [2:0]          r_creq_size;
    logic [ADDR_W-1:0]   r_creq_addr;
    logic [STRB_W-1:0]   r_creq_strobe;
    logic [DATA_W-1:0]   r_creq_wdata;

    logic w_last;
    logic w_any_req;
    logic w_favour_d;
    logic w_pick_d;
    logic w_load;

    assign w_last    = cresp_ready && cresp_last;
    assign w_any_req = i_req_valid || d_req_valid;
    assign w_pick_d  = d_req_valid && (!i_req_valid || w_favour_d);
    assign w_load    = (r_state == ST_IDLE) && w_any_req;

`ifdef CBUS_ARB_RR_EN
    logic r_favour_d;

    // After every grant the other requester gets precedence on the next tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_favour_d <= 1'b1;
        end else if (w_load) begin
            r_favour_d <= !w_pick_d;
        end
    end

    assign w_favour_d = r_favour_d;
`else
    assign w_favour_d = 1'b1;
`endif

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_next = w_pick_d ? ST_GRANT_D : ST_GRANT_I;
                end
            end
            ST_GRANT_I, ST_GRANT_D: begin
                if (w_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: state and request register use non-blocking assignments so all flops update together.
    // NOTE: the request register is reset as well, because its contents drive creq_* directly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_creq_valid  <= 1'b0;
            r_creq_write  <= 1'b0;
            r_creq_size   <= 3'd0;
            r_creq_addr   <= '0;
            r_creq_strobe <= '0;
            r_creq_wdata  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_creq_valid <= (w_state_next != ST_IDLE);
            if (w_load) begin
                if (w_pick_d) begin
                    r_creq_write  <= d_req_write;
                    r_creq_size   <= d_req_size;
                    r_creq_addr   <= d_req_addr;
                    r_creq_strobe <= d_req_strobe;
                    r_creq_wdata  <= d_req_wdata;
                end else begin
                    // fetches are always 4-byte reads
                    r_creq_write  <= 1'b0;
                    r_creq_size   <= 3'd2;
                    r_creq_addr   <= i_req_addr;
                    r_creq_strobe <= '0;
                    r_creq_wdata  <= '0;
                end
            end
        end
    end

    assign creq_valid  = r_creq_valid;
    assign creq_write  = r_creq_write;
    assign creq_size   = r_creq_size;
    assign creq_addr   = r_creq_addr;
    assign creq_strobe = r_creq_strobe;
    assign creq_wdata  = r_creq_wdata;

    assign i_data_ok = (r_state == ST_GRANT_I) && w_last;
    assign d_data_ok = (r_state == ST_GRANT_D) && w_last;
    assign i_data    = i_data_ok ? cresp_data[31:0] : 32'd0;
    assign d_data    = d_data_ok ? cresp_data : '0;

    // Stalls are held low while in reset so every output reads 0 then.
    assign i_wait = resetn && i_req_valid && !i_data_ok;
    assign d_wait = resetn && d_req_valid && !d_data_ok;

endmodule
